// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA timing, pixel clock, registered sync/blank/colour
// x/y feed a combinational video generator; its colour is captured one pixel later with syncs.
module vga_timing_gen #(
  parameter int PIX_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic       vga_clk,
  output logic       vga_hs_n,
  output logic       vga_vs_n,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(PIX_DIV);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic          pix_tick;
  logic          line_end;
  logic          frame_end;
  logic          hs_on;
  logic          vs_on;
  logic          act;
  logic          wrapped;

  assign pix_tick  = (div_cnt == DW'(PIX_DIV - 1));
  assign div_nxt   = pix_tick ? '0 : div_cnt + DW'(1);
  assign line_end  = (x == 10'(H_TOTAL - 1));
  assign frame_end = line_end && (y == 10'(V_TOTAL - 1));

  assign hs_on = (x >= 10'(H_ACTIVE + H_FP)) && (x <= 10'(H_ACTIVE + H_FP + H_SYNC - 1));
  assign vs_on = (y >= 10'(V_ACTIVE + V_FP)) && (y <= 10'(V_ACTIVE + V_FP + V_SYNC - 1));
  assign act   = (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));

  assign vga_sync_n = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      vga_clk     <= 1'b0;
      x           <= '0;
      y           <= '0;
      wrapped     <= 1'b0;
      frame_start <= 1'b0;
      vga_hs_n    <= 1'b1;
      vga_vs_n    <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      div_cnt <= div_nxt;
      vga_clk <= (div_nxt >= DW'(PIX_DIV / 2));
      // wrapped marks the clk after x,y return to (0,0); frame_start follows it
      wrapped     <= pix_tick && frame_end;
      frame_start <= wrapped;
      if (pix_tick) begin
        if (line_end) begin
          x <= '0;
          y <= frame_end ? '0 : y + 10'd1;
        end else begin
          x <= x + 10'd1;
        end
        vga_hs_n    <= !hs_on;
        vga_vs_n    <= !vs_on;
        vga_blank_n <= act;
        vga_r       <= act ? r : 8'd0;
        vga_g       <= act ? g : 8'd0;
        vga_b       <= act ? b : 8'd0;
      end
    end
  end

endmodule
